// File: rtl/mpc_qp_admm_pkg.sv
// rtl/mpc_qp_admm_pkg.sv - requester ids and lock-owner encoding shared by the RAM arbiter
package mpc_qp_admm_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_A    = 2'd1,
    LOCK_B    = 2'd2
  } lock_state_t;

endpackage

// File: rtl/mpc_qp_admm_vx_ram_arb_if.sv
// rtl/mpc_qp_admm_vx_ram_arb_if.sv - two-requester RAM access bus; lock wires only with MPC_ARB_LOCK_EN
interface mpc_qp_admm_vx_ram_arb_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5
);
  logic                    a_req, b_req;
  logic                    a_we, b_we;
  logic [AddressWidth-1:0] a_addr, b_addr;
  logic [DataWidth-1:0]    a_wdata, b_wdata;
`ifdef MPC_ARB_LOCK_EN
  logic                    a_lock, b_lock;
`endif
  logic                    a_gnt, b_gnt;
  logic                    a_rvalid, b_rvalid;
  logic [DataWidth-1:0]    a_rdata, b_rdata;

`ifdef MPC_ARB_LOCK_EN
  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, a_lock, b_lock,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata
  );
  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, a_lock, b_lock,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata
  );
`else
  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata
  );
  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata
  );
`endif

endinterface

// File: rtl/mpc_qp_admm_rr_arb2.sv
// rtl/mpc_qp_admm_rr_arb2.sv - two-way round-robin grant with optional ownership lock (MPC_ARB_LOCK_EN)
module mpc_qp_admm_rr_arb2
  import mpc_qp_admm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
`ifdef MPC_ARB_LOCK_EN
  input  logic a_lock,
  input  logic b_lock,
`endif
  output logic a_gnt,
  output logic b_gnt
);

  // prio_q names the requester that wins the next tie
  req_id_t prio_q, prio_d;
`ifdef MPC_ARB_LOCK_EN
  lock_state_t lock_q, lock_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= REQ_A;
`ifdef MPC_ARB_LOCK_EN
      lock_q <= LOCK_NONE;
`endif
    end else begin
      prio_q <= prio_d;
`ifdef MPC_ARB_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    prio_d = prio_q;
`ifdef MPC_ARB_LOCK_EN
    lock_d = LOCK_NONE;
    // an owner whose request has dropped loses the lock and normal arbitration resumes
    if (reset && lock_q == LOCK_A && a_req)
      a_gnt = 1'b1;
    else if (reset && lock_q == LOCK_B && b_req)
      b_gnt = 1'b1;
    else
`endif
    if (reset && a_req && (!b_req || prio_q == REQ_A))
      a_gnt = 1'b1;
    else if (reset && b_req)
      b_gnt = 1'b1;

    if (a_gnt) prio_d = REQ_B;
    if (b_gnt) prio_d = REQ_A;
`ifdef MPC_ARB_LOCK_EN
    if (a_gnt && a_lock) lock_d = LOCK_A;
    if (b_gnt && b_lock) lock_d = LOCK_B;
`endif
  end

endmodule

// File: rtl/mpc_qp_admm_vx_ram_arb.sv
// rtl/mpc_qp_admm_vx_ram_arb.sv - shares one single-port RAM between requesters A and B; lock option MPC_ARB_LOCK_EN
module mpc_qp_admm_vx_ram_arb
  import mpc_qp_admm_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int AddressRange = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  mpc_qp_admm_vx_ram_arb_if.slave bus,
  output logic [AddressWidth-1:0] ram_address0,
  output logic                    ram_ce0,
  output logic                    ram_we0,
  output logic [DataWidth-1:0]    ram_d0,
  input  logic [DataWidth-1:0]    ram_q0,
  output logic                    err_addr
);

  localparam logic [AddressWidth:0] RangeEnd = (AddressWidth + 1)'(AddressRange);

  logic                    a_gnt, b_gnt, any_gnt;
  logic                    sel_we, in_range;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth-1:0]    sel_wdata;
  logic                    a_rv_q, b_rv_q, oor_q, err_q;
  logic [DataWidth-1:0]    rdata_sel;

  mpc_qp_admm_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .a_req  (bus.a_req),
    .b_req  (bus.b_req),
`ifdef MPC_ARB_LOCK_EN
    .a_lock (bus.a_lock),
    .b_lock (bus.b_lock),
`endif
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  always_comb begin
    any_gnt   = a_gnt | b_gnt;
    sel_we    = b_gnt ? bus.b_we    : bus.a_we;
    sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
    sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
    in_range  = {1'b0, sel_addr} < RangeEnd;
  end

  // out-of-range accesses are consumed without touching the RAM
  assign ram_ce0      = any_gnt & in_range;
  assign ram_we0      = ram_ce0 & sel_we;
  assign ram_address0 = any_gnt ? sel_addr  : '0;
  assign ram_d0       = any_gnt ? sel_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      oor_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_rv_q <= a_gnt & ~sel_we;
      b_rv_q <= b_gnt & ~sel_we;
      oor_q  <= ~in_range;
      if (any_gnt && !in_range) err_q <= 1'b1;
    end
  end

  assign rdata_sel    = oor_q ? '0 : ram_q0;
  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rv_q;
  assign bus.b_rvalid = b_rv_q;
  assign bus.a_rdata  = a_rv_q ? rdata_sel : '0;
  assign bus.b_rdata  = b_rv_q ? rdata_sel : '0;
  assign err_addr     = err_q;

endmodule

// File: tb/tb_mpc_qp_admm_vx_ram_arb.sv
// tb/tb_mpc_qp_admm_vx_ram_arb.sv - scoreboard bench for the A/B RAM arbiter; lock scenario with MPC_ARB_LOCK_EN
module tb_mpc_qp_admm_vx_ram_arb;

  localparam int RANGE = 24;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ram_address0;
  logic        ram_ce0, ram_we0, err_addr;
  logic [31:0] ram_d0, ram_q0;
  logic        a_lock_v = 1'b0, b_lock_v = 1'b0;

  logic [31:0] ram    [0:31];
  logic [31:0] shadow [0:31];
  exp_t        qa [$];
  exp_t        qb [$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        m_last_b = 1'b1;
  int          m_lock = 0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  mpc_qp_admm_vx_ram_arb_if #(.DataWidth(32), .AddressWidth(5)) bus ();

`ifdef MPC_ARB_LOCK_EN
  assign bus.a_lock = a_lock_v;
  assign bus.b_lock = b_lock_v;
`endif

  mpc_qp_admm_vx_ram_arb #(.DataWidth(32), .AddressWidth(5), .AddressRange(RANGE)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_address0 (ram_address0),
    .ram_ce0      (ram_ce0),
    .ram_we0      (ram_we0),
    .ram_d0       (ram_d0),
    .ram_q0       (ram_q0),
    .err_addr     (err_addr)
  );

  // read-first single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_ce0) begin
      ram_q0 <= ram[ram_address0];
      if (ram_we0) ram[ram_address0] = ram_d0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, expv, cyc);
    end
  endfunction

  // reference: grants, RAM contents and the error flag derived from the access rules
  always @(negedge clk) begin : model_chk
    logic ea, eb, w, lk, inr;
    logic [4:0] ad;
    logic [31:0] dt;
    if (!reset) begin
      chk("rst_a_gnt", bus.a_gnt, 0);
      chk("rst_b_gnt", bus.b_gnt, 0);
      chk("rst_ram_ce0", ram_ce0, 0);
      chk("rst_ram_we0", ram_we0, 0);
      chk("rst_err_addr", err_addr, 0);
      qa.delete();
      qb.delete();
      m_last_b = 1'b1;
      m_lock = 0;
      m_err = 1'b0;
    end else begin
      ea = 1'b0;
      eb = 1'b0;
      if (m_lock == 1 && bus.a_req) ea = 1'b1;
      else if (m_lock == 2 && bus.b_req) eb = 1'b1;
      else if (bus.a_req && bus.b_req) begin
        if (m_last_b) ea = 1'b1;
        else eb = 1'b1;
      end else begin
        ea = bus.a_req;
        eb = bus.b_req;
      end
      chk("a_gnt", bus.a_gnt, ea);
      chk("b_gnt", bus.b_gnt, eb);
      chk("err_addr", err_addr, m_err);
      if (ea || eb) begin
        ad  = ea ? bus.a_addr  : bus.b_addr;
        w   = ea ? bus.a_we    : bus.b_we;
        dt  = ea ? bus.a_wdata : bus.b_wdata;
        lk  = ea ? a_lock_v    : b_lock_v;
        inr = (int'(ad) < RANGE);
        chk("ram_ce0", ram_ce0, inr);
        if (inr) begin
          chk("ram_address0", ram_address0, ad);
          chk("ram_we0", ram_we0, w);
          if (w) chk("ram_d0", ram_d0, dt);
        end else begin
          m_err = 1'b1;
        end
        if (!w) begin
          if (ea) qa.push_back('{due: cyc + 1, data: inr ? shadow[ad] : 32'h0});
          else    qb.push_back('{due: cyc + 1, data: inr ? shadow[ad] : 32'h0});
        end else if (inr) begin
          shadow[ad] = dt;
        end
        m_last_b = eb;
        m_lock = !lk ? 0 : (ea ? 1 : 2);
      end else begin
        chk("ram_ce0_idle", ram_ce0, 0);
        m_lock = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (!reset) begin
      chk("rst_a_rvalid", bus.a_rvalid, 0);
      chk("rst_b_rvalid", bus.b_rvalid, 0);
    end else begin
      if (qa.size() > 0 && qa[0].due <= cyc) begin
        chk("a_rvalid", bus.a_rvalid, 1);
        chk("a_rdata", bus.a_rdata, qa[0].data);
        qa.delete(0);
      end else begin
        chk("a_rvalid_idle", bus.a_rvalid, 0);
        chk("a_rdata_idle", bus.a_rdata, 0);
      end
      if (qb.size() > 0 && qb[0].due <= cyc) begin
        chk("b_rvalid", bus.b_rvalid, 1);
        chk("b_rdata", bus.b_rdata, qb[0].data);
        qb.delete(0);
      end else begin
        chk("b_rvalid_idle", bus.b_rvalid, 0);
        chk("b_rdata_idle", bus.b_rdata, 0);
      end
    end
  end

  task automatic set_a(input logic r, input logic w, input logic [4:0] ad, input logic [31:0] d, input logic lk);
    bus.a_req = r; bus.a_we = w; bus.a_addr = ad; bus.a_wdata = d; a_lock_v = lk;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [4:0] ad, input logic [31:0] d, input logic lk);
    bus.b_req = r; bus.b_we = w; bus.b_addr = ad; bus.b_wdata = d; b_lock_v = lk;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic lock_rand();
`ifdef MPC_ARB_LOCK_EN
    return ($urandom_range(0, 3) == 0);
`else
    return 1'b0;
`endif
  endfunction

  initial begin : stim
    logic ga, gb;
    for (int i = 0; i < 32; i++) begin
      ram[i]    = 32'hC0DE0000 + i;
      shadow[i] = 32'hC0DE0000 + i;
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    do_reset();

    // both requesters read continuously: strict alternation starting with A
    set_a(1, 0, 5'd1, 0, 0);
    set_b(1, 0, 5'd2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_a_order", bus.a_gnt, (i % 2) == 0);
      chk("rr_b_order", bus.b_gnt, (i % 2) == 1);
      next_cycle();
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    set_a(1, 1, 5'd3, 32'h3F800000, 0);
    @(negedge clk); chk("wr3_gnt", bus.a_gnt, 1);
    next_cycle();
    set_a(1, 0, 5'd3, 0, 0);
    @(negedge clk); chk("rd3_gnt", bus.a_gnt, 1);
    next_cycle();
    set_a(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd3_rvalid", bus.a_rvalid, 1);
    chk("rd3_rdata", bus.a_rdata, 32'h3F800000);
    next_cycle();

    set_b(1, 0, 5'd24, 0, 0);
    @(negedge clk);
    chk("oor_gnt", bus.b_gnt, 1);
    chk("oor_ce", ram_ce0, 0);
    next_cycle();
    set_b(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("oor_rvalid", bus.b_rvalid, 1);
    chk("oor_rdata", bus.b_rdata, 0);
    chk("oor_err", err_addr, 1);
    repeat (3) next_cycle();
    @(negedge clk); chk("oor_err_sticky", err_addr, 1);
    next_cycle();

    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ga = bus.a_gnt;
      gb = bus.b_gnt;
      next_cycle();
      if (!bus.a_req || ga)
        set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 26)), $urandom, lock_rand());
      if (!bus.b_req || gb)
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 26)), $urandom, lock_rand());
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (3) next_cycle();

`ifdef MPC_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_a(1, 0, 5'd5, 0, i < 3);
      set_b(1, 0, 5'd9, 0, 0);
      @(negedge clk);
      chk("lock_a_gnt", bus.a_gnt, i < 4);
      chk("lock_b_gnt", bus.b_gnt, i == 4);
      next_cycle();
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (3) next_cycle();
`endif

    // reset arrives while A's read is in flight
    set_a(1, 0, 5'd5, 0, 0);
    @(negedge clk); chk("flight_gnt", bus.a_gnt, 1);
    next_cycle();
    reset = 1'b0;
    set_a(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flight_rvalid_rst", bus.a_rvalid, 0);
    chk("flight_rdata_rst", bus.a_rdata, 0);
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flight_rvalid_after", bus.a_rvalid, 0);
      chk("flight_err_after", err_addr, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
